rv32_bus_responder: RTL and testbench
=====================================

Name: rv32_bus_responder

Overview:
- Responder end of the core's instruction/data bus handshake: accepts the fetch port (instr_read/instr_ready) and the memory-stage port (data_read/data_write/data_ready).
- Arbitrates both ports onto one downstream single-port memory bus with its own ready handshake.
- Returns the ready pulses that the pipeline's stall logic consumes.
- Sits between the rv32 core top and the SoC memory/peripheral fabric.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- DATA_WIDTH, 32, width of data ports; mask width is DATA_WIDTH/8.

Ports:
- clk  input  1  clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- instr_address_in  input  ADDR_WIDTH  fetch address.
- instr_read_in  input  1  fetch request, held until instr_ready_out.
- instr_read_value_out  output  DATA_WIDTH  fetched word, valid when instr_ready_out.
- instr_ready_out  output  1  one-cycle completion pulse for the fetch port.
- data_address_in  input  ADDR_WIDTH  load/store address.
- data_read_in  input  1  load request.
- data_write_in  input  1  store request.
- data_write_mask_in  input  DATA_WIDTH/8  byte enables for stores.
- data_write_value_in  input  DATA_WIDTH  store data.
- data_read_value_out  output  DATA_WIDTH  load data, valid when data_ready_out.
- data_ready_out  output  1  one-cycle completion pulse for the data port.
- mem_address_out  output  ADDR_WIDTH  downstream address.
- mem_read_out  output  1  downstream read strobe.
- mem_write_out  output  1  downstream write strobe.
- mem_write_mask_out  output  DATA_WIDTH/8  downstream byte enables.
- mem_write_value_out  output  DATA_WIDTH  downstream write data.
- mem_read_value_in  input  DATA_WIDTH  downstream read data.
- mem_ready_in  input  1  downstream completion; meaningful only while a strobe is high.

Behaviour:
- FSM states: IDLE, INSTR, DATA. Reset puts the FSM in IDLE and sets last_grant = INSTR.
- Reset values of outputs: all strobes 0, both ready outputs 0, all registered address/value/mask outputs 0.
- Requests:
  - Fetch request = instr_read_in.
  - Data request = data_read_in || data_write_in.
  - data_read_in and data_write_in both high is illegal; if it happens, the write wins.
- IDLE arbitration, evaluated each cycle:
  - Only one port requesting: grant that port.
  - Both requesting: grant the port that is not last_grant (round robin).
  - So after reset a simultaneous request goes to DATA first.
- On grant:
  - Latch address, and for DATA also mask, value and read/write kind, into registers.
  - Update last_grant.
  - Move to INSTR or DATA next cycle.
- INSTR state:
  - mem_read_out = 1, mem_write_out = 0.
  - mem_write_mask_out = 0.
  - mem_address_out = latched address.
- DATA state:
  - mem_read_out or mem_write_out per the latched kind.
  - mask and value driven from the latched registers.
- Completion:
  - In INSTR/DATA, when mem_ready_in = 1, the granted port's ready output is 1 in the same cycle; it is combinational from mem_ready_in and state.
  - The corresponding read_value output passes mem_read_value_in.
  - FSM returns to IDLE next cycle.
  - The non-granted ready output stays 0.
  - read_value outputs are don't-care when their ready is low; drive mem_read_value_in on both.
- Latency:
  - A request first seen in IDLE at cycle N gets downstream strobes at N+1.
  - Earliest ready is at N+1 (zero-wait memory).
  - Back-to-back transactions leave one IDLE cycle between them; IDLE re-arbitrates in the cycle after ready.
- Request dropped after grant: this is a protocol violation. The downstream transaction still completes, the ready pulse is still issued, and the latched values are used.
- Requests arriving while not in IDLE are not sampled; the core holds them per protocol.
- mem_ready_in high while in IDLE is ignored and no ready output pulses.
- Reset asserted mid-transaction: next cycle FSM is IDLE and strobes are 0; the in-flight downstream transaction is abandoned.

Decomposition:
- Shared package rv32_bus_pkg holds:
  - the grant/state enum (IDLE, INSTR, DATA);
  - the port-select type for last_grant;
  - the default width constants.
- No sub-module; a single flat module.

Test Plan:
- Fetch-only: instr_read_in = 1, address 0x100; mem_ready_in high on the first strobe cycle with value 0x00000013 -> mem_read_out and mem_address_out = 0x100 at N+1; instr_ready_out = 1 with instr_read_value_out = 0x13 at N+1; FSM in IDLE at N+2.
- Simultaneous after reset: fetch 0x200 and store 0x8000/mask 0xF/value 0xDEADBEEF -> DATA granted first with mem_write_out = 1. After data_ready_out, INSTR is granted on the following IDLE cycle.
- Round robin: both ports requesting continuously for 4 transactions -> grant order DATA, INSTR, DATA, INSTR; each ready pulses exactly once per transaction.
- Wait states: load 0x40, mem_ready_in held low 3 cycles -> data_ready_out stays 0 for 3 cycles with strobe and address stable; ready pulses exactly one cycle when mem_ready_in rises.
- Reset mid-transaction: reset asserted while in DATA with mem_ready_in low -> next cycle all strobes and ready outputs are 0; a later fetch starts normally.
- Request dropped: instr_read_in deasserted after grant while the address input changes to 0x999 -> mem_address_out stays at the latched address; instr_ready_out still pulses on mem_ready_in.

Source files
------------

// File: rtl/rv32_bus_pkg.sv
// rv32_bus_pkg
// Shared types and default widths for the rv32 bus responder.
//   bus_state_e : responder FSM state, doubling as the current grant
//                 (IDLE = nothing granted, INSTR = fetch port, DATA = data port)
//   port_sel_e  : which port was granted most recently (round-robin memory)
//   DEF_*_WIDTH : default address/data widths
package rv32_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_DATA  = 2'd2
  } bus_state_e;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_sel_e;

endpackage

// File: rtl/rv32_bus_responder.sv
// rv32_bus_responder
// Arbitrates the core's fetch port and data port onto one single-port
// downstream memory bus and returns one-cycle ready pulses to the core.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr_*                    fetch port: address/read in, value/ready out
//   data_*                     data port: address/read/write/mask/value in,
//                              value/ready out
//   mem_*                      downstream bus: address/strobes/mask/value out,
//                              read value/ready in
module rv32_bus_responder
  import rv32_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     instr_address_in,
  input  logic                      instr_read_in,
  output logic [DATA_WIDTH-1:0]     instr_read_value_out,
  output logic                      instr_ready_out,
  input  logic [ADDR_WIDTH-1:0]     data_address_in,
  input  logic                      data_read_in,
  input  logic                      data_write_in,
  input  logic [DATA_WIDTH/8-1:0]   data_write_mask_in,
  input  logic [DATA_WIDTH-1:0]     data_write_value_in,
  output logic [DATA_WIDTH-1:0]     data_read_value_out,
  output logic                      data_ready_out,
  output logic [ADDR_WIDTH-1:0]     mem_address_out,
  output logic                      mem_read_out,
  output logic                      mem_write_out,
  output logic [DATA_WIDTH/8-1:0]   mem_write_mask_out,
  output logic [DATA_WIDTH-1:0]     mem_write_value_out,
  input  logic [DATA_WIDTH-1:0]     mem_read_value_in,
  input  logic                      mem_ready_in
);

  bus_state_e                r_state;
  bus_state_e                w_state_next;
  port_sel_e                 r_last_grant;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH/8-1:0]   r_mask;
  logic [DATA_WIDTH-1:0]     r_value;
  logic                      r_is_write;

  logic w_fetch_req;
  logic w_data_req;
  logic w_grant_instr;
  logic w_grant_data;

  assign w_fetch_req = instr_read_in;
  assign w_data_req  = data_read_in | data_write_in;

  // Next state, grant decision and bus outputs.
  always_comb begin
    w_state_next         = r_state;
    w_grant_instr        = 1'b0;
    w_grant_data         = 1'b0;
    mem_read_out         = 1'b0;
    mem_write_out        = 1'b0;
    instr_ready_out      = 1'b0;
    data_ready_out       = 1'b0;
    // Read data is only meaningful alongside its ready pulse, so both
    // ports simply see the downstream read bus.
    instr_read_value_out = mem_read_value_in;
    data_read_value_out  = mem_read_value_in;

    case (r_state)
      ST_IDLE: begin
        // Data wins when it is alone, or when both request and the fetch
        // port had the previous grant.
        if (w_data_req && (!w_fetch_req || r_last_grant == PORT_INSTR)) begin
          w_grant_data = 1'b1;
          w_state_next = ST_DATA;
        end else if (w_fetch_req) begin
          w_grant_instr = 1'b1;
          w_state_next  = ST_INSTR;
        end
      end
      ST_INSTR: begin
        mem_read_out    = 1'b1;
        instr_ready_out = mem_ready_in;
        if (mem_ready_in) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        mem_read_out   = ~r_is_write;
        mem_write_out  = r_is_write;
        data_ready_out = mem_ready_in;
        if (mem_ready_in) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Mask and value registers are cleared on a fetch grant so the INSTR
  // state drives a zero byte-enable without extra output muxing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PORT_INSTR;
      r_addr       <= '0;
      r_mask       <= '0;
      r_value      <= '0;
      r_is_write   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_data) begin
        r_last_grant <= PORT_DATA;
        r_addr       <= data_address_in;
        r_mask       <= data_write_mask_in;
        r_value      <= data_write_value_in;
        r_is_write   <= data_write_in;   // write wins over an illegal read+write
      end else if (w_grant_instr) begin
        r_last_grant <= PORT_INSTR;
        r_addr       <= instr_address_in;
        r_mask       <= '0;
        r_value      <= '0;
        r_is_write   <= 1'b0;
      end
    end
  end

  assign mem_address_out     = r_addr;
  assign mem_write_mask_out  = r_mask;
  assign mem_write_value_out = r_value;

endmodule

// File: tb/tb_rv32_bus_responder.sv
module tb_rv32_bus_responder;

  logic        clk;
  logic        reset;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [31:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic [31:0] mem_address_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [3:0]  mem_write_mask_out;
  logic [31:0] mem_write_value_out;
  logic [31:0] mem_read_value_in;
  logic        mem_ready_in;

  int n_cmp = 0;
  int n_bad = 0;

  rv32_bus_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_address_in    (instr_address_in),
    .instr_read_in       (instr_read_in),
    .instr_read_value_out(instr_read_value_out),
    .instr_ready_out     (instr_ready_out),
    .data_address_in     (data_address_in),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_write_value_in (data_write_value_in),
    .data_read_value_out (data_read_value_out),
    .data_ready_out      (data_ready_out),
    .mem_address_out     (mem_address_out),
    .mem_read_out        (mem_read_out),
    .mem_write_out       (mem_write_out),
    .mem_write_mask_out  (mem_write_mask_out),
    .mem_write_value_out (mem_write_value_out),
    .mem_read_value_in   (mem_read_value_in),
    .mem_ready_in        (mem_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One outstanding transaction at most; owner chosen by round robin.
  bit          m_started = 0;
  bit          m_busy    = 0;
  bit          m_is_data = 0;
  bit          m_last_data = 0;
  logic [31:0] m_addr  = '0;
  logic [3:0]  m_mask  = '0;
  logic [31:0] m_value = '0;
  bit          m_write = 0;

  always @(posedge clk) begin
    bit want_i, want_d, pick_d;
    m_started = 1;
    want_i = instr_read_in;
    want_d = data_read_in || data_write_in;
    if (reset) begin
      m_busy = 0; m_last_data = 0;
    end else if (m_busy) begin
      if (mem_ready_in) begin
        $display("txn %s addr=%h %s value=%h", m_is_data ? "DATA " : "INSTR", m_addr,
                 m_write ? "wr" : "rd", m_write ? m_value : mem_read_value_in);
        m_busy = 0;
      end
    end else if (want_i || want_d) begin
      pick_d = (want_i && want_d) ? !m_last_data : want_d;
      m_busy = 1; m_is_data = pick_d; m_last_data = pick_d;
      if (pick_d) begin
        m_addr = data_address_in; m_mask = data_write_mask_in;
        m_value = data_write_value_in; m_write = data_write_in;
      end else begin
        m_addr = instr_address_in; m_mask = 4'h0; m_write = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      bit e_rd, e_wr, e_ir, e_dr;
      e_rd = m_busy && (!m_is_data || !m_write);
      e_wr = m_busy && m_is_data && m_write;
      e_ir = m_busy && !m_is_data && mem_ready_in;
      e_dr = m_busy && m_is_data && mem_ready_in;
      chk("model mem_read", {31'b0, mem_read_out}, {31'b0, e_rd});
      chk("model mem_write", {31'b0, mem_write_out}, {31'b0, e_wr});
      chk("model instr_ready", {31'b0, instr_ready_out}, {31'b0, e_ir});
      chk("model data_ready", {31'b0, data_ready_out}, {31'b0, e_dr});
      if (m_busy) begin
        chk("model mem_address", mem_address_out, m_addr);
        chk("model mem_mask", {28'b0, mem_write_mask_out}, {28'b0, m_mask});
      end
      if (e_wr) chk("model mem_value", mem_write_value_out, m_value);
      if (e_ir) chk("model instr_value", instr_read_value_out, mem_read_value_in);
      if (e_dr) chk("model data_value", data_read_value_out, mem_read_value_in);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_read_in = 0; data_read_in = 0; data_write_in = 0;
    mem_ready_in = 0;
  endtask

  initial begin
    reset = 1;
    instr_address_in = '0; instr_read_in = 0;
    data_address_in = '0; data_read_in = 0; data_write_in = 0;
    data_write_mask_in = '0; data_write_value_in = '0;
    mem_read_value_in = '0; mem_ready_in = 0;
    tick(); tick();
    #3;
    chk("reset mem_read", {31'b0, mem_read_out}, 32'd0);
    chk("reset mem_write", {31'b0, mem_write_out}, 32'd0);
    chk("reset mem_address", mem_address_out, 32'd0);
    chk("reset mem_mask", {28'b0, mem_write_mask_out}, 32'd0);
    chk("reset mem_value", mem_write_value_out, 32'd0);
    chk("reset readies", {30'b0, instr_ready_out, data_ready_out}, 32'd0);

    // Fetch-only, zero-wait. mem_ready high in IDLE must be ignored.
    tick(); reset = 0;
    tick();
    instr_read_in = 1; instr_address_in = 32'h100;
    mem_ready_in = 1; mem_read_value_in = 32'h0000_0013;
    #3;
    chk("fetch N instr_ready", {31'b0, instr_ready_out}, 32'd0);
    chk("fetch N mem_read", {31'b0, mem_read_out}, 32'd0);
    tick();
    #3;
    chk("fetch N+1 mem_read", {31'b0, mem_read_out}, 32'd1);
    chk("fetch N+1 address", mem_address_out, 32'h100);
    chk("fetch N+1 instr_ready", {31'b0, instr_ready_out}, 32'd1);
    chk("fetch N+1 value", instr_read_value_out, 32'h13);
    tick(); idle_inputs();
    #3;
    chk("fetch N+2 idle", {30'b0, mem_read_out, mem_write_out}, 32'd0);

    // Simultaneous after reset: data first, then fetch.
    tick(); reset = 1;
    tick(); reset = 0;
    instr_read_in = 1; instr_address_in = 32'h200;
    data_write_in = 1; data_address_in = 32'h8000;
    data_write_mask_in = 4'hF; data_write_value_in = 32'hDEAD_BEEF;
    tick(); mem_ready_in = 1;
    #3;
    chk("sim data write", {30'b0, mem_read_out, mem_write_out}, 32'd1);
    chk("sim data address", mem_address_out, 32'h8000);
    chk("sim data mask", {28'b0, mem_write_mask_out}, 32'hF);
    chk("sim data value", mem_write_value_out, 32'hDEAD_BEEF);
    chk("sim data ready", {30'b0, instr_ready_out, data_ready_out}, 32'd1);
    tick(); data_write_in = 0; mem_ready_in = 0;
    #3;
    chk("sim gap idle", {30'b0, mem_read_out, mem_write_out}, 32'd0);
    tick(); mem_ready_in = 1; mem_read_value_in = 32'h1234_5678;
    #3;
    chk("sim instr read", {30'b0, mem_read_out, mem_write_out}, 32'd2);
    chk("sim instr address", mem_address_out, 32'h200);
    chk("sim instr mask", {28'b0, mem_write_mask_out}, 32'd0);
    chk("sim instr ready", {30'b0, instr_ready_out, data_ready_out}, 32'd2);
    tick(); idle_inputs();

    // Round robin: both ports hold requests, zero-wait memory.
    tick();
    instr_read_in = 1; instr_address_in = 32'h300;
    data_read_in = 1; data_address_in = 32'h400; mem_ready_in = 1;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] exp_rdy;
      exp_rdy = (k % 4 == 1) ? 32'd1 : ((k % 4 == 3) ? 32'd2 : 32'd0);
      mem_read_value_in = 32'hA000_0000 + k;
      #3;
      chk($sformatf("rr cycle %0d readies", k), {30'b0, instr_ready_out, data_ready_out}, exp_rdy);
      tick();
    end
    idle_inputs();

    // Wait states on a load.
    tick();
    data_read_in = 1; data_address_in = 32'h40;
    for (int k = 0; k < 3; k++) begin
      tick();
      #3;
      chk($sformatf("wait %0d data_ready", k), {31'b0, data_ready_out}, 32'd0);
      chk($sformatf("wait %0d strobe", k), {30'b0, mem_read_out, mem_write_out}, 32'd2);
      chk($sformatf("wait %0d address", k), mem_address_out, 32'h40);
    end
    tick(); mem_ready_in = 1; mem_read_value_in = 32'hCAFE_F00D;
    #3;
    chk("wait done data_ready", {31'b0, data_ready_out}, 32'd1);
    chk("wait done value", data_read_value_out, 32'hCAFE_F00D);
    tick(); data_read_in = 0;
    #3;
    chk("wait after ready", {30'b0, instr_ready_out, data_ready_out}, 32'd0);
    tick(); idle_inputs();

    // Reset in the middle of a store with the memory stalling.
    tick();
    data_write_in = 1; data_address_in = 32'h44;
    data_write_mask_in = 4'h3; data_write_value_in = 32'h0000_BEEF;
    tick();
    #3;
    chk("rst mid write strobe", {31'b0, mem_write_out}, 32'd1);
    reset = 1;
    tick(); reset = 0; idle_inputs();
    #3;
    chk("rst mid strobes", {30'b0, mem_read_out, mem_write_out}, 32'd0);
    chk("rst mid readies", {30'b0, instr_ready_out, data_ready_out}, 32'd0);
    chk("rst mid address", mem_address_out, 32'd0);
    tick();
    instr_read_in = 1; instr_address_in = 32'h300;
    tick(); mem_ready_in = 1; mem_read_value_in = 32'h0000_0093;
    #3;
    chk("rst later fetch addr", mem_address_out, 32'h300);
    chk("rst later fetch ready", {30'b0, instr_ready_out, data_ready_out}, 32'd2);
    tick(); idle_inputs();

    // Fetch request dropped after grant while the address wanders.
    tick();
    instr_read_in = 1; instr_address_in = 32'h500;
    tick(); instr_read_in = 0; instr_address_in = 32'h999;
    #3;
    chk("drop address held", mem_address_out, 32'h500);
    chk("drop strobe", {31'b0, mem_read_out}, 32'd1);
    tick(); mem_ready_in = 1; mem_read_value_in = 32'h0000_0517;
    #3;
    chk("drop instr_ready", {31'b0, instr_ready_out}, 32'd1);
    chk("drop address still", mem_address_out, 32'h500);
    tick(); mem_ready_in = 0;
    #3;
    chk("drop back idle", {30'b0, mem_read_out, mem_write_out}, 32'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
